// File: rtl/bus_register_bank.sv
// SLC-3 architectural state behind the bus gate: PC, IR, MAR, MDR, R0-R7, NZP, BEN.
// Ports: Clk/Reset_n; Bus, ADDR_SUM, MEM_RDATA sources; LD_* strobes; PCMUX/MIO_EN/DRMUX/SR1MUX
// selects; PC/IR/MAR/MDR/NZP/BEN state; SR1_OUT/SR2_OUT/ALU_B combinational reads.
module bus_register_bank #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [W-1:0] Bus,
  input  logic         LD_PC,
  input  logic         LD_IR,
  input  logic         LD_MAR,
  input  logic         LD_MDR,
  input  logic         LD_REG,
  input  logic         LD_CC,
  input  logic         LD_BEN,
  input  logic [1:0]   PCMUX,
  input  logic [W-1:0] ADDR_SUM,
  input  logic         MIO_EN,
  input  logic [W-1:0] MEM_RDATA,
  input  logic         DRMUX,
  input  logic         SR1MUX,
  output logic [W-1:0] PC,
  output logic [W-1:0] IR,
  output logic [W-1:0] MAR,
  output logic [W-1:0] MDR,
  output logic [W-1:0] SR1_OUT,
  output logic [W-1:0] SR2_OUT,
  output logic [W-1:0] ALU_B,
  output logic [2:0]   NZP,
  output logic         BEN
);

  logic [W-1:0] r_pc;
  logic [W-1:0] r_ir;
  logic [W-1:0] r_mar;
  logic [W-1:0] r_mdr;
  logic [W-1:0] r_rf [NREG];
  logic [2:0]   r_nzp;
  logic         r_ben;

  logic [W-1:0] w_pc_next;
  logic [W-1:0] w_mdr_next;
  logic [2:0]   w_nzp_next;
  logic         w_ben_next;
  logic [2:0]   w_dr;
  logic [2:0]   w_sr1;
  logic [2:0]   w_sr2;
  logic [W-1:0] w_sr1_data;
  logic [W-1:0] w_sr2_data;
  logic [W-1:0] w_imm5;
  logic         w_n;
  logic         w_z;

  always_comb begin
    w_pc_next = r_pc;
    unique case (PCMUX)
      2'b00:   w_pc_next = r_pc + W'(1);
      2'b01:   w_pc_next = Bus;
      2'b10:   w_pc_next = ADDR_SUM;
      default: w_pc_next = r_pc;
    endcase
  end

  assign w_mdr_next = MIO_EN ? MEM_RDATA : Bus;

  // N and Z are mutually exclusive, so P = !N & !Z keeps the code one-hot.
  assign w_n        = Bus[W-1];
  assign w_z        = (Bus == '0);
  assign w_nzp_next = {w_n, w_z, ~w_n & ~w_z};

  // Uses registered IR/NZP, so same-edge LD_IR or LD_CC cannot leak in.
  assign w_ben_next = |(r_ir[11:9] & r_nzp);

  assign w_dr  = DRMUX  ? 3'd7        : r_ir[11:9];
  assign w_sr1 = SR1MUX ? r_ir[8:6]   : r_ir[11:9];
  assign w_sr2 = r_ir[2:0];

  assign w_sr1_data = r_rf[w_sr1];
  assign w_sr2_data = r_rf[w_sr2];
  assign w_imm5     = {{(W-5){r_ir[4]}}, r_ir[4:0]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_nzp <= 3'b010;
      r_ben <= 1'b0;
    end else begin
      if (LD_PC)  r_pc  <= w_pc_next;
      if (LD_IR)  r_ir  <= Bus;
      if (LD_MAR) r_mar <= Bus;
      if (LD_MDR) r_mdr <= w_mdr_next;
      if (LD_CC)  r_nzp <= w_nzp_next;
      if (LD_BEN) r_ben <= w_ben_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (LD_REG) begin
      r_rf[w_dr] <= Bus;
    end
  end

  assign PC      = r_pc;
  assign IR      = r_ir;
  assign MAR     = r_mar;
  assign MDR     = r_mdr;
  assign NZP     = r_nzp;
  assign BEN     = r_ben;
  assign SR1_OUT = w_sr1_data;
  assign SR2_OUT = w_sr2_data;
  assign ALU_B   = r_ir[5] ? w_imm5 : w_sr2_data;

endmodule

// File: tb/tb_bus_register_bank.sv
// Scoreboard bench for bus_register_bank: directed plan plus random strobes.
// Driver pushes model expectations; a separate monitor pops and compares.
module tb_bus_register_bank;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] Bus;
  logic        LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN;
  logic [1:0]  PCMUX;
  logic [15:0] ADDR_SUM;
  logic        MIO_EN;
  logic [15:0] MEM_RDATA;
  logic        DRMUX;
  logic        SR1MUX;
  logic [15:0] PC, IR, MAR, MDR, SR1_OUT, SR2_OUT, ALU_B;
  logic [2:0]  NZP;
  logic        BEN;

  bus_register_bank #(.W(16), .NREG(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Bus(Bus),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .PCMUX(PCMUX), .ADDR_SUM(ADDR_SUM), .MIO_EN(MIO_EN),
    .MEM_RDATA(MEM_RDATA), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .ALU_B(ALU_B),
    .NZP(NZP), .BEN(BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          rst;
    bit          ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben;
    bit [1:0]    pcmux;
    bit [15:0]   bus, addr, mem;
    bit          mio, drmux, sr1mux;
  } stim_t;

  typedef struct {
    string       tag;
    bit [15:0]   pc, ir, mar, mdr, sr1, sr2, alub;
    bit [2:0]    nzp;
    bit          ben;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  bit [15:0] m_pc, m_ir, m_mar, m_mdr;
  bit [15:0] m_rf [8];
  bit [2:0]  m_nzp;
  bit        m_ben;

  function automatic void m_reset();
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 0;
    m_nzp = 3'b010;
    m_ben = 0;
  endfunction

  function automatic exp_t m_view(string tag, bit sr1mux);
    exp_t e;
    int   imm;
    int   s1;
    e.tag = tag;
    e.pc = m_pc; e.ir = m_ir; e.mar = m_mar; e.mdr = m_mdr;
    e.nzp = m_nzp; e.ben = m_ben;
    s1 = sr1mux ? int'(m_ir[8:6]) : int'(m_ir[11:9]);
    e.sr1 = m_rf[s1];
    e.sr2 = m_rf[m_ir[2:0]];
    imm = int'(m_ir[4:0]);
    if (imm >= 16) imm = imm - 32;
    e.alub = m_ir[5] ? 16'(imm) : e.sr2;
    return e;
  endfunction

  function automatic void m_step(stim_t s);
    bit [15:0] pc_n, ir_n, mar_n, mdr_n;
    bit [2:0]  nzp_n;
    bit        ben_n;
    int        dr;
    pc_n = m_pc; ir_n = m_ir; mar_n = m_mar; mdr_n = m_mdr;
    nzp_n = m_nzp; ben_n = m_ben;
    if (s.ld_pc)
      case (s.pcmux)
        2'd0: pc_n = 16'((int'(m_pc) + 1) % 65536);
        2'd1: pc_n = s.bus;
        2'd2: pc_n = s.addr;
        default: pc_n = m_pc;
      endcase
    if (s.ld_ir)  ir_n = s.bus;
    if (s.ld_mar) mar_n = s.bus;
    if (s.ld_mdr) mdr_n = s.mio ? s.mem : s.bus;
    if (s.ld_cc) begin
      if (s.bus >= 16'h8000)  nzp_n = 3'b100;
      else if (s.bus == 0)    nzp_n = 3'b010;
      else                    nzp_n = 3'b001;
    end
    if (s.ld_ben) ben_n = (m_ir[11:9] & m_nzp) != 0;
    dr = s.drmux ? 7 : int'(m_ir[11:9]);
    if (s.ld_reg) m_rf[dr] = s.bus;
    m_pc = pc_n; m_ir = ir_n; m_mar = mar_n; m_mdr = mdr_n;
    m_nzp = nzp_n; m_ben = ben_n;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Driver: drives at negedge, pushes pre-edge and post-edge expectations.
  task automatic cyc(input stim_t s, input string tag);
    @(negedge Clk);
    Bus = s.bus; ADDR_SUM = s.addr; MEM_RDATA = s.mem;
    LD_PC = s.ld_pc; LD_IR = s.ld_ir; LD_MAR = s.ld_mar;
    LD_MDR = s.ld_mdr; LD_REG = s.ld_reg; LD_CC = s.ld_cc;
    LD_BEN = s.ld_ben; PCMUX = s.pcmux; MIO_EN = s.mio;
    DRMUX = s.drmux; SR1MUX = s.sr1mux;
    q.push_back(m_view({tag, "/pre"}, s.sr1mux));
    if (s.rst) m_reset();
    m_step(s);
    q.push_back(m_view({tag, "/post"}, s.sr1mux));
    if (s.rst) begin
      #2 Reset_n = 1'b0;
      #1 Reset_n = 1'b1;
    end
  endtask

  task automatic chk(string tag, string f, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", tag, f, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk or negedge Clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(e.tag, "PC", PC, e.pc);
        chk(e.tag, "IR", IR, e.ir);
        chk(e.tag, "MAR", MAR, e.mar);
        chk(e.tag, "MDR", MDR, e.mdr);
        chk(e.tag, "SR1", SR1_OUT, e.sr1);
        chk(e.tag, "SR2", SR2_OUT, e.sr2);
        chk(e.tag, "ALUB", ALU_B, e.alub);
        chk(e.tag, "NZP", {13'd0, NZP}, {13'd0, e.nzp});
        chk(e.tag, "BEN", {15'd0, BEN}, {15'd0, e.ben});
      end
    end
  end

  initial begin
    stim_t s;
    Reset_n = 1'b0;
    Bus = 0; ADDR_SUM = 0; MEM_RDATA = 0;
    LD_PC = 0; LD_IR = 0; LD_MAR = 0; LD_MDR = 0;
    LD_REG = 0; LD_CC = 0; LD_BEN = 0;
    PCMUX = 0; MIO_EN = 0; DRMUX = 0; SR1MUX = 0;
    m_reset();
    #12 Reset_n = 1'b1;

    s = idle(); cyc(s, "reset");
    s = idle(); s.ld_pc = 1; s.pcmux = 1; s.bus = 16'hFFFF; cyc(s, "pc_set");
    s = idle(); s.ld_pc = 1; s.pcmux = 0; cyc(s, "pc_wrap");
    s = idle(); s.ld_pc = 1; s.pcmux = 1; s.bus = 16'h3000; cyc(s, "pc_bus");
    s = idle(); s.ld_pc = 1; s.pcmux = 2; s.addr = 16'h1234; cyc(s, "pc_addr");
    s = idle(); s.ld_pc = 1; s.pcmux = 3; s.bus = 16'h5555; cyc(s, "pc_hold");

    s = idle(); s.ld_ir = 1; s.bus = 16'h1A42; cyc(s, "ir_1a42");
    s = idle(); s.ld_reg = 1; s.bus = 16'h1111; cyc(s, "r5_init");
    s = idle(); s.ld_reg = 1; s.bus = 16'hBEEF; cyc(s, "r5_beef");
    s = idle(); s.sr1mux = 1; cyc(s, "sr1_r1");
    s = idle(); s.ld_reg = 1; s.drmux = 1; s.bus = 16'h7777; cyc(s, "r7_wr");
    s = idle(); s.ld_ir = 1; s.bus = 16'h0400; cyc(s, "ir_dr2");
    s = idle(); s.ld_reg = 1; s.bus = 16'h2222; cyc(s, "r2_wr");
    s = idle(); s.ld_ir = 1; s.bus = 16'h003F; cyc(s, "alub_imm");
    s = idle(); s.ld_ir = 1; s.bus = 16'h0002; cyc(s, "alub_r2");
    s = idle(); s.ld_ir = 1; s.ld_reg = 1; s.bus = 16'h0E00; cyc(s, "ir_reg_same");

    s = idle(); s.ld_cc = 1; s.bus = 16'h8000; cyc(s, "cc_n");
    s = idle(); s.ld_cc = 1; s.bus = 16'h0000; cyc(s, "cc_z");
    s = idle(); s.ld_cc = 1; s.bus = 16'h0001; cyc(s, "cc_p");
    s = idle(); s.ld_ir = 1; s.bus = 16'h0200; cyc(s, "ir_0200");
    s = idle(); s.ld_ben = 1; cyc(s, "ben_1");
    s = idle(); s.ld_cc = 1; s.ld_ben = 1; s.bus = 16'h0000; cyc(s, "ben_oldcc");
    s = idle(); s.ld_ben = 1; cyc(s, "ben_0");
    s = idle(); s.ld_ir = 1; s.ld_ben = 1; s.bus = 16'h0400; cyc(s, "ben_oldir");

    s = idle(); s.ld_mdr = 1; s.mio = 1; s.mem = 16'hA5A5; s.bus = 16'h1111;
    cyc(s, "mdr_mem");
    s = idle(); s.ld_mdr = 1; s.ld_mar = 1; s.mio = 0; s.mem = 16'hA5A5;
    s.bus = 16'h1111; cyc(s, "mdr_bus");
    s = idle(); s.ld_pc = 1; s.pcmux = 0; s.ld_mar = 1; s.bus = 16'h4444;
    cyc(s, "pc_mar");

    s = idle(); s.ld_ir = 1; s.ld_pc = 1; s.pcmux = 1; s.bus = 16'h1A42;
    s.rst = 1; cyc(s, "async_rst");
    s = idle(); cyc(s, "after_rst");

    for (int i = 0; i < 400; i++) begin
      s.rst    = ($urandom_range(0, 49) == 0);
      s.ld_pc  = $urandom_range(0, 1) != 0;
      s.ld_ir  = $urandom_range(0, 2) == 0;
      s.ld_mar = $urandom_range(0, 1) != 0;
      s.ld_mdr = $urandom_range(0, 1) != 0;
      s.ld_reg = $urandom_range(0, 1) != 0;
      s.ld_cc  = $urandom_range(0, 1) != 0;
      s.ld_ben = $urandom_range(0, 1) != 0;
      s.pcmux  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: s.bus = 16'h0000;
        1: s.bus = 16'hFFFF;
        default: s.bus = 16'($urandom);
      endcase
      s.addr   = 16'($urandom);
      s.mem    = 16'($urandom);
      s.mio    = $urandom_range(0, 1) != 0;
      s.drmux  = $urandom_range(0, 1) != 0;
      s.sr1mux = $urandom_range(0, 1) != 0;
      cyc(s, "rand");
    end

    s = idle(); cyc(s, "drain");
    @(posedge Clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_register_bank.md
# bus_register_bank

Architectural state of the SLC-3 datapath that sits directly downstream of the one-hot bus gate: PC, IR, MAR, MDR, an 8×16 register file, the NZP condition codes and the BEN branch-enable flag. Each register loads from the shared 16-bit bus (or its dedicated source) under a load strobe from the control unit. Register-file read ports, the ALU B operand and the branch flag are presented back to the datapath.

## Interface
Parameters:
- W, 16, datapath/bus width
- NREG, 8, register-file depth (index width fixed at 3)

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Bus  in  W  shared datapath bus (output of the gate stage)
- LD_PC, LD_IR, LD_MAR, LD_MDR, LD_REG, LD_CC, LD_BEN  in  1 each  load strobes
- PCMUX  in  2  PC next-value select
- ADDR_SUM  in  W  address-adder result
- MIO_EN  in  1  MDR source select: 1 = MEM_RDATA, 0 = Bus
- MEM_RDATA  in  W  memory read data
- DRMUX  in  1  destination select: 0 = IR[11:9], 1 = R7
- SR1MUX  in  1  SR1 select: 0 = IR[11:9], 1 = IR[8:6]
- PC, IR, MAR, MDR  out  W each  register contents
- SR1_OUT, SR2_OUT  out  W each  register-file read data
- ALU_B  out  W  ALU B operand
- NZP  out  3  condition codes {N,Z,P}
- BEN  out  1  branch enable

## Operation
- Reset (Reset_n low, asynchronous): PC, IR, MAR, MDR = 0x0000; all R0–R7 = 0x0000; NZP = 3'b010; BEN = 0. The state is held while Reset_n is low, and the first load takes effect on the first rising edge after release.
- PC on LD_PC, selected by PCMUX:
  - 00: PC+1 (mod 2^W; 0xFFFF wraps to 0x0000)
  - 01: Bus
  - 10: ADDR_SUM
  - 11: PC (hold)
- IR ← Bus on LD_IR.
- MAR ← Bus on LD_MAR.
- MDR ← (MIO_EN ? MEM_RDATA : Bus) on LD_MDR.
- Register file:
  - Write address DR = DRMUX ? 3'd7 : IR[11:9]. On LD_REG, R[DR] ← Bus.
  - Reads are combinational from current contents. SR1 = SR1MUX ? IR[8:6] : IR[2:0]… corrected: SR1 = SR1MUX ? IR[8:6] : IR[11:9]; SR2 = IR[2:0].
  - No write-to-read bypass: in a write cycle, reads return the old value, and the new value is visible the next cycle.
- ALU_B = IR[5] ? sign-extend(IR[4:0]) to W : SR2_OUT.
- NZP on LD_CC, from Bus: N = Bus[W-1]; Z = (Bus == 0); P = !N && !Z. Exactly one bit is ever set.
- BEN on LD_BEN: BEN ← |(IR[11:9] & NZP), using the registered IR and NZP values before the edge.
- Simultaneous strobes: all registers update on the same edge from pre-edge values.
  - LD_IR + LD_BEN: BEN uses the old IR.
  - LD_CC + LD_BEN: BEN uses the old NZP.
  - LD_IR + LD_REG: DR is decoded from the old IR.
  - LD_PC with PCMUX = 00 + LD_MAR: MAR gets Bus, not the new PC.
- Strobes with no load asserted: all state holds. No illegal encodings exist.

## Timing
- All state is rising-edge registered; every register update is visible 1 cycle after its strobe.
- SR1_OUT, SR2_OUT and ALU_B are combinational from IR and the register file, so they change in the same cycle that IR or a register changes.
- Bus and MEM_RDATA must be stable at the edge where their strobe is sampled. The block has no internal wait states.
- Reset assertion clears outputs without a clock. Deassertion is synchronous to Clk upstream; the block requires no extra cycles after deassertion.

## Test plan
- Reset: load nonzero values everywhere, pulse Reset_n low between edges → immediately PC = IR = MAR = MDR = 0, R0–R7 = 0, NZP = 010, BEN = 0.
- PC sources, from PC = 0xFFFF:
  - LD_PC, PCMUX = 00 → 0x0000.
  - PCMUX = 01, Bus = 0x3000 → 0x3000.
  - PCMUX = 10, ADDR_SUM = 0x1234 → 0x1234.
  - PCMUX = 11 → holds 0x1234.
- Register file and DRMUX:
  - IR = 0x1A42 (DR = 5, SR1 = 1, SR2 = 2), Bus = 0xBEEF, LD_REG → SR1_OUT = old R5 in the write cycle, R5 = 0xBEEF next cycle.
  - DRMUX = 1 writes R7.
  - ALU_B with IR = 0x003F → 0xFFFF; with IR = 0x0002 → R2.
- Condition codes with LD_CC:
  - Bus = 0x8000 → NZP = 100.
  - Bus = 0x0000 → 010.
  - Bus = 0x0001 → 001.
- BEN ordering, with NZP = 001 and IR = 0x0200 (n=0, z=0, p=1):
  - LD_BEN → BEN = 1.
  - Same-edge LD_CC with Bus = 0x0000 plus LD_BEN → BEN = 1 (old NZP); following LD_BEN → 0.
- MDR source: MIO_EN = 1, MEM_RDATA = 0xA5A5, Bus = 0x1111, LD_MDR → MDR = 0xA5A5; MIO_EN = 0 → 0x1111. Same edge with LD_MAR → MAR = 0x1111.
